// File: rtl/cs_address_sequencer_if.sv
// ----------------------------------------------------------------------------
// cs_address_sequencer_if
// Bundles the microcode-store fields, datapath status and sequencer outputs
// exchanged with cs_address_sequencer. Signal names match the legacy
// sequencer ports so existing hookups map one-to-one.
//
//   master : microcode store / datapath side (drives condition, jump address,
//            RD/WR, MemReady, IR, ALU flags, FlagWrite; observes outputs)
//   slave  : the sequencer itself
//
// Optional feature macro: CSSEQ_BREAKPOINT_EN adds the breakpoint signals
// (BkptAddr, BkptEnable, Resume, Halted).
// ----------------------------------------------------------------------------
interface cs_address_sequencer_if #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32
);
    logic [DATAWIDTH_CONDITION-1:0]   CSSEQ_Condition_InBus;
    logic [DATAWIDTH_JUMPADDRESS-1:0] CSSEQ_JumpAddress_InBus;
    logic                             CSSEQ_RD_In;
    logic                             CSSEQ_WR_In;
    logic                             CSSEQ_MemReady_In;
    logic [DATAWIDTH_IR-1:0]          CSSEQ_IR_InBus;
    logic [3:0]                       CSSEQ_ALUFlags_InBus;
    logic                             CSSEQ_FlagWrite_In;
    logic [DATAWIDTH_JUMPADDRESS-1:0] CSSEQ_CSAddress_OutBus;
    logic [3:0]                       CSSEQ_Flags_OutBus;
    logic                             CSSEQ_Stall_Out;
`ifdef CSSEQ_BREAKPOINT_EN
    logic [DATAWIDTH_JUMPADDRESS-1:0] CSSEQ_BkptAddr_InBus;
    logic                             CSSEQ_BkptEnable_In;
    logic                             CSSEQ_Resume_In;
    logic                             CSSEQ_Halted_Out;

    modport master (
        output CSSEQ_Condition_InBus, CSSEQ_JumpAddress_InBus, CSSEQ_RD_In,
               CSSEQ_WR_In, CSSEQ_MemReady_In, CSSEQ_IR_InBus,
               CSSEQ_ALUFlags_InBus, CSSEQ_FlagWrite_In,
               CSSEQ_BkptAddr_InBus, CSSEQ_BkptEnable_In, CSSEQ_Resume_In,
        input  CSSEQ_CSAddress_OutBus, CSSEQ_Flags_OutBus, CSSEQ_Stall_Out,
               CSSEQ_Halted_Out
    );

    modport slave (
        input  CSSEQ_Condition_InBus, CSSEQ_JumpAddress_InBus, CSSEQ_RD_In,
               CSSEQ_WR_In, CSSEQ_MemReady_In, CSSEQ_IR_InBus,
               CSSEQ_ALUFlags_InBus, CSSEQ_FlagWrite_In,
               CSSEQ_BkptAddr_InBus, CSSEQ_BkptEnable_In, CSSEQ_Resume_In,
        output CSSEQ_CSAddress_OutBus, CSSEQ_Flags_OutBus, CSSEQ_Stall_Out,
               CSSEQ_Halted_Out
    );
`else
    modport master (
        output CSSEQ_Condition_InBus, CSSEQ_JumpAddress_InBus, CSSEQ_RD_In,
               CSSEQ_WR_In, CSSEQ_MemReady_In, CSSEQ_IR_InBus,
               CSSEQ_ALUFlags_InBus, CSSEQ_FlagWrite_In,
        input  CSSEQ_CSAddress_OutBus, CSSEQ_Flags_OutBus, CSSEQ_Stall_Out
    );

    modport slave (
        input  CSSEQ_Condition_InBus, CSSEQ_JumpAddress_InBus, CSSEQ_RD_In,
               CSSEQ_WR_In, CSSEQ_MemReady_In, CSSEQ_IR_InBus,
               CSSEQ_ALUFlags_InBus, CSSEQ_FlagWrite_In,
        output CSSEQ_CSAddress_OutBus, CSSEQ_Flags_OutBus, CSSEQ_Stall_Out
    );
`endif
endinterface

// File: rtl/cs_address_sequencer.sv
// ----------------------------------------------------------------------------
// cs_address_sequencer
// Control-store address sequencer for the ARC microarchitecture. Selects the
// next 11-bit control-store address from the microinstruction condition field
// (increment, flag/IR[13] conditional jump, unconditional jump, or opcode
// decode), holds the PSR flags {n,z,v,c}, and stalls while a memory access
// is outstanding.
//
// Ports:
//   CSSEQ_CLOCK_50       clock, all state changes on the rising edge
//   CSSEQ_ResetInLow_In  synchronous reset, active low
//   bus (slave)          microinstruction fields, datapath status and the
//                        registered CSAddress / Flags / Stall outputs
//
// Optional feature macro: CSSEQ_BREAKPOINT_EN adds a HALT state entered when
// a loaded address matches BkptAddr while BkptEnable is set; Resume leaves it.
// ----------------------------------------------------------------------------
module cs_address_sequencer #(
    parameter int DATAWIDTH_JUMPADDRESS = 11,
    parameter int DATAWIDTH_CONDITION   = 3,
    parameter int DATAWIDTH_IR          = 32
) (
    input logic                   CSSEQ_CLOCK_50,
    input logic                   CSSEQ_ResetInLow_In,
    cs_address_sequencer_if.slave bus
);
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
`ifdef CSSEQ_BREAKPOINT_EN
    localparam logic [1:0] ST_HALT = 2'd2;
`endif

    logic [DATAWIDTH_JUMPADDRESS-1:0] addr_q, addr_d;
    logic [3:0]                       flags_q, flags_d;
    logic [1:0]                       state_q, state_d;
`ifdef CSSEQ_BREAKPOINT_EN
    // Set by Resume so the first load after a halt never re-triggers.
    logic                             bkpt_skip_q, bkpt_skip_d;
`endif

    logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr;
    logic [DATAWIDTH_JUMPADDRESS-1:0] decode_addr;
    logic [5:0]                       decode_f;
    logic [DATAWIDTH_IR-1:0]          ir;
    logic                             load;
    logic                             ir_unused;

    assign ir        = bus.CSSEQ_IR_InBus;
    assign ir_unused = ^{ir[29:25], ir[18:14], ir[12:0]};

    // Opcode decode: {1, op, F, 00}; format-3 uses op3, format-2 op2, call none.
    always_comb begin
        decode_f = '0;
        if (ir[31])
            decode_f = ir[24:19];
        else if (!ir[30])
            decode_f = {ir[24:22], 3'b000};
        decode_addr = {1'b1, ir[31:30], decode_f, 2'b00};
    end

    // Branch tests use the registered PSR, not this cycle's ALU flags.
    always_comb begin
        next_addr = addr_q + 1'b1;
        case (bus.CSSEQ_Condition_InBus)
            3'd1: if (flags_q[3]) next_addr = bus.CSSEQ_JumpAddress_InBus;
            3'd2: if (flags_q[2]) next_addr = bus.CSSEQ_JumpAddress_InBus;
            3'd3: if (flags_q[1]) next_addr = bus.CSSEQ_JumpAddress_InBus;
            3'd4: if (flags_q[0]) next_addr = bus.CSSEQ_JumpAddress_InBus;
            3'd5: if (ir[13])     next_addr = bus.CSSEQ_JumpAddress_InBus;
            3'd6: next_addr = bus.CSSEQ_JumpAddress_InBus;
            3'd7: next_addr = decode_addr;
            default: ;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        flags_d = flags_q;
        state_d = state_q;
        load    = 1'b0;
`ifdef CSSEQ_BREAKPOINT_EN
        bkpt_skip_d = bkpt_skip_q;
`endif
        case (state_q)
            ST_RUN: begin
                if ((bus.CSSEQ_RD_In || bus.CSSEQ_WR_In) && !bus.CSSEQ_MemReady_In)
                    state_d = ST_WAIT;
                else
                    load = 1'b1;
            end
            ST_WAIT: begin
                if (bus.CSSEQ_MemReady_In) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
`ifdef CSSEQ_BREAKPOINT_EN
            ST_HALT: begin
                if (bus.CSSEQ_Resume_In) begin
                    state_d     = ST_RUN;
                    bkpt_skip_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_RUN;
        endcase

        if (load) begin
            addr_d = next_addr;
            if (bus.CSSEQ_FlagWrite_In)
                flags_d = bus.CSSEQ_ALUFlags_InBus;
`ifdef CSSEQ_BREAKPOINT_EN
            bkpt_skip_d = 1'b0;
            if (!bkpt_skip_q && bus.CSSEQ_BkptEnable_In &&
                next_addr == bus.CSSEQ_BkptAddr_InBus)
                state_d = ST_HALT;
`endif
        end
    end

    always_ff @(posedge CSSEQ_CLOCK_50) begin
        if (!CSSEQ_ResetInLow_In) begin
            addr_q  <= '0;
            flags_q <= '0;
            state_q <= ST_RUN;
`ifdef CSSEQ_BREAKPOINT_EN
            bkpt_skip_q <= 1'b0;
`endif
        end else begin
            addr_q  <= addr_d;
            flags_q <= flags_d;
            state_q <= state_d;
`ifdef CSSEQ_BREAKPOINT_EN
            bkpt_skip_q <= bkpt_skip_d;
`endif
        end
    end

    assign bus.CSSEQ_CSAddress_OutBus = addr_q;
    assign bus.CSSEQ_Flags_OutBus     = flags_q;
    assign bus.CSSEQ_Stall_Out        = (state_q == ST_WAIT);
`ifdef CSSEQ_BREAKPOINT_EN
    assign bus.CSSEQ_Halted_Out       = (state_q == ST_HALT);
`endif
endmodule

// File: tb/tb_cs_address_sequencer.sv
module tb_cs_address_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cs_address_sequencer_if bus ();

    cs_address_sequencer dut (
        .CSSEQ_CLOCK_50      (clk),
        .CSSEQ_ResetInLow_In (rst_n),
        .bus                 (bus)
    );

    typedef struct {
        int addr;
        int flags;
        int stall;
        int halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_addr, m_flags;
    bit m_wait, m_halt, m_skip;

    // Breakpoint stimulus (only driven into the DUT when the feature exists)
    int bk_addr = 0;
    bit bk_en   = 1'b0;
    bit resume  = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int m_next(input int cond, input int jump,
                                  input logic [31:0] ir, input int flags,
                                  input int addr);
        int inc;
        int op;
        int f;
        inc = (addr + 1) % 2048;
        op  = int'(ir >> 30);
        if (op >= 2)      f = int'((ir >> 19) & 32'd63);
        else if (op == 0) f = int'((ir >> 22) & 32'd7) * 8;
        else              f = 0;
        case (cond)
            1, 2, 3, 4: return ((flags >> (4 - cond)) & 1) != 0 ? jump : inc;
            5:          return ir[13] ? jump : inc;
            6:          return jump;
            7:          return 1024 + op * 256 + f * 4;
            default:    return inc;
        endcase
    endfunction

    task automatic set_in(input int cond, input int jump, input bit rd, input bit wr,
                          input bit mr, input logic [31:0] ir, input int alu, input bit fw);
        bus.CSSEQ_Condition_InBus   = cond[2:0];
        bus.CSSEQ_JumpAddress_InBus = jump[10:0];
        bus.CSSEQ_RD_In             = rd;
        bus.CSSEQ_WR_In             = wr;
        bus.CSSEQ_MemReady_In       = mr;
        bus.CSSEQ_IR_InBus          = ir;
        bus.CSSEQ_ALUFlags_InBus    = alu[3:0];
        bus.CSSEQ_FlagWrite_In      = fw;
`ifdef CSSEQ_BREAKPOINT_EN
        bus.CSSEQ_BkptAddr_InBus    = bk_addr[10:0];
        bus.CSSEQ_BkptEnable_In     = bk_en;
        bus.CSSEQ_Resume_In         = resume;
`endif
    endtask

    // Advance one clock: update the model from the applied inputs, then queue
    // the outputs the DUT must show after this edge.
    task automatic tick();
        exp_t e;
        int   nxt;
        bit   access;
        access = bus.CSSEQ_RD_In || bus.CSSEQ_WR_In;
        if (!rst_n) begin
            m_addr = 0; m_flags = 0; m_wait = 0; m_halt = 0; m_skip = 0;
        end else if (m_halt) begin
            if (resume) begin
                m_halt = 0;
                m_skip = 1;
            end
        end else if (!m_wait && access && !bus.CSSEQ_MemReady_In) begin
            m_wait = 1;
        end else if (m_wait && !bus.CSSEQ_MemReady_In) begin
            m_wait = 1;
        end else begin
            nxt = m_next(int'(bus.CSSEQ_Condition_InBus), int'(bus.CSSEQ_JumpAddress_InBus),
                         bus.CSSEQ_IR_InBus, m_flags, m_addr);
            if (bus.CSSEQ_FlagWrite_In) m_flags = int'(bus.CSSEQ_ALUFlags_InBus);
            m_addr = nxt;
            m_wait = 0;
`ifdef CSSEQ_BREAKPOINT_EN
            if (!m_skip && bk_en && nxt == bk_addr) m_halt = 1;
`endif
            m_skip = 0;
        end
        @(posedge clk);
        #1;
        e.addr   = m_addr;
        e.flags  = m_flags;
        e.stall  = m_wait ? 1 : 0;
        e.halted = m_halt ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("csaddress", int'(bus.CSSEQ_CSAddress_OutBus), e.addr);
            chk("flags",     int'(bus.CSSEQ_Flags_OutBus),     e.flags);
            chk("stall",     int'(bus.CSSEQ_Stall_Out),        e.stall);
`ifdef CSSEQ_BREAKPOINT_EN
            chk("halted",    int'(bus.CSSEQ_Halted_Out),       e.halted);
`endif
        end
    end

    localparam logic [31:0] IR_ADDCC0 = 32'h8280_4002;
    localparam logic [31:0] IR_ADDCC1 = 32'h8280_6002;

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, '0, 0, 0);
        tick(); tick();
        chk("reset_addr", int'(bus.CSSEQ_CSAddress_OutBus), 0);
        chk("reset_flags", int'(bus.CSSEQ_Flags_OutBus), 0);
        rst_n = 1'b1;

        // Sequential increment
        tick(); chk("inc1", int'(bus.CSSEQ_CSAddress_OutBus), 1);
        tick(); chk("inc2", int'(bus.CSSEQ_CSAddress_OutBus), 2);

        // Reset while waiting on memory
        set_in(0, 0, 1, 0, 0, '0, 0, 0);
        tick(); tick();
        chk("wait_stall", int'(bus.CSSEQ_Stall_Out), 1);
        rst_n = 1'b0;
        tick();
        chk("rst_wait_addr", int'(bus.CSSEQ_CSAddress_OutBus), 0);
        chk("rst_wait_stall", int'(bus.CSSEQ_Stall_Out), 0);
        rst_n = 1'b1;

        // Decode and IR[13] branch
        set_in(7, 0, 0, 0, 0, IR_ADDCC0, 0, 0);
        tick(); chk("decode_addcc", int'(bus.CSSEQ_CSAddress_OutBus), 1600);
        set_in(5, 1602, 0, 0, 0, IR_ADDCC0, 0, 0);
        tick(); chk("ir13_clear", int'(bus.CSSEQ_CSAddress_OutBus), 1601);
        set_in(5, 1602, 0, 0, 0, IR_ADDCC1, 0, 0);
        tick(); chk("ir13_set", int'(bus.CSSEQ_CSAddress_OutBus), 1602);

        // Zero-flag branch
        set_in(2, 100, 0, 0, 0, '0, 0, 0);
        tick(); chk("z_clear", int'(bus.CSSEQ_CSAddress_OutBus), 1603);
        set_in(0, 0, 0, 0, 0, '0, 4, 1);
        tick(); chk("flag_write", int'(bus.CSSEQ_Flags_OutBus), 4);
        set_in(2, 100, 0, 0, 0, '0, 15, 0);
        tick(); chk("z_set", int'(bus.CSSEQ_CSAddress_OutBus), 100);
        chk("flag_hold", int'(bus.CSSEQ_Flags_OutBus), 4);

        // Memory stall of three cycles, then an immediate-ready access
        rst_n = 1'b0; set_in(0, 0, 0, 0, 0, '0, 0, 0); tick(); rst_n = 1'b1;
        set_in(0, 0, 1, 0, 0, '0, 9, 1);
        repeat (3) begin
            tick();
            chk("stall_hi", int'(bus.CSSEQ_Stall_Out), 1);
            chk("stall_addr", int'(bus.CSSEQ_CSAddress_OutBus), 0);
        end
        chk("stall_flags", int'(bus.CSSEQ_Flags_OutBus), 0);
        set_in(0, 0, 1, 0, 1, '0, 9, 1);
        tick();
        chk("wait_exit_addr", int'(bus.CSSEQ_CSAddress_OutBus), 1);
        chk("wait_exit_stall", int'(bus.CSSEQ_Stall_Out), 0);
        chk("wait_exit_flags", int'(bus.CSSEQ_Flags_OutBus), 9);
        set_in(0, 0, 1, 1, 1, '0, 0, 0);
        tick();
        chk("ready_now_addr", int'(bus.CSSEQ_CSAddress_OutBus), 2);
        chk("ready_now_stall", int'(bus.CSSEQ_Stall_Out), 0);

        // Wrap and unconditional jump
        set_in(6, 2047, 0, 0, 0, '0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, '0, 0, 0);    tick();
        chk("wrap", int'(bus.CSSEQ_CSAddress_OutBus), 0);
        set_in(6, 1234, 0, 0, 0, '0, 15, 1); tick();
        chk("jump_always", int'(bus.CSSEQ_CSAddress_OutBus), 1234);

`ifdef CSSEQ_BREAKPOINT_EN
        rst_n = 1'b0; set_in(0, 0, 0, 0, 0, '0, 0, 0); tick(); rst_n = 1'b1;
        bk_addr = 1600; bk_en = 1'b1;
        set_in(7, 0, 0, 0, 0, IR_ADDCC0, 0, 0);
        tick();
        chk("bkpt_addr", int'(bus.CSSEQ_CSAddress_OutBus), 1600);
        chk("bkpt_halted", int'(bus.CSSEQ_Halted_Out), 1);
        set_in(0, 0, 0, 0, 0, '0, 5, 1);
        repeat (5) tick();
        chk("halt_hold", int'(bus.CSSEQ_CSAddress_OutBus), 1600);
        resume = 1'b1; set_in(0, 0, 0, 0, 0, '0, 0, 0); tick();
        resume = 1'b0; set_in(0, 0, 0, 0, 0, '0, 0, 0); tick();
        chk("resume_addr", int'(bus.CSSEQ_CSAddress_OutBus), 1601);
        chk("resume_halted", int'(bus.CSSEQ_Halted_Out), 0);
        bk_en = 1'b0;
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int cond;
            int jump;
            cond  = int'($urandom_range(0, 7));
            jump  = int'($urandom_range(0, 2047));
            rst_n = ($urandom_range(0, 99) != 0);
`ifdef CSSEQ_BREAKPOINT_EN
            bk_en   = ($urandom_range(0, 1) == 1);
            bk_addr = ($urandom_range(0, 1) == 1) ? jump : int'($urandom_range(0, 2047));
            resume  = ($urandom_range(0, 3) == 0);
`endif
            set_in(cond, jump,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 2) == 0, $urandom,
                   int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
            tick();
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
